// File: rtl/md_filter_pkg.sv
// Shared definitions for the filter-bank schedulers: FSM state encoding,
// statistics counter width and a one-hot to index helper.
package md_filter_pkg;

    localparam int unsigned STATS_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        STALL  = ST_STALL
    } sched_state_t;

    typedef logic [STATS_W-1:0] stat_cnt_t;

    // OR-reduction encoder: valid only for a one-hot (or zero) input
    function automatic logic [3:0] onehot_to_index(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/filter_rr_scheduler_if.sv
// Handshake bundle between the filter buffer bank and the round-robin
// read scheduler. The scheduler drives the master side.
interface filter_rr_scheduler_if #(
    parameter int unsigned NUM_FILTER = 4,
    parameter int unsigned ID_WIDTH   = 2
);
    logic [NUM_FILTER-1:0] filter_available;
    logic                  pipe_ready;
    logic [NUM_FILTER-1:0] arbitration_result;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  sel_valid;
    logic [2:0]            inflight_cnt;
    logic                  arb_busy;

    modport master (
        input  filter_available, pipe_ready,
        output arbitration_result, sel_id, sel_valid, inflight_cnt, arb_busy
    );

    modport slave (
        output filter_available, pipe_ready,
        input  arbitration_result, sel_id, sel_valid, inflight_cnt, arb_busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches the request vector starting at
// the pointer, wrapping modulo NUM_FILTER, and returns a one-hot grant and
// its index.
module rr_pick
    import md_filter_pkg::*;
#(
    parameter int unsigned NUM_FILTER = 4,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic [NUM_FILTER-1:0] i_req,
    input  logic [ID_WIDTH-1:0]   i_ptr,
    input  logic                  i_en,
    output logic [NUM_FILTER-1:0] o_grant,
    output logic [ID_WIDTH-1:0]   o_idx,
    output logic                  o_any
);
    localparam int unsigned PW = $clog2(NUM_FILTER);

    logic [PW-1:0] w_pos;
    int unsigned   w_sum;
    logic          w_found;
    logic [15:0]   w_oh16;
    logic [3:0]    w_idx4;

    // First requester at or after the pointer wins
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_pos   = '0;
        w_sum   = 0;
        for (int unsigned i = 0; i < NUM_FILTER; i++) begin
            w_sum = 32'(i_ptr) + i;
            if (w_sum >= NUM_FILTER) w_sum = w_sum - NUM_FILTER;
            w_pos = PW'(w_sum);
            if (i_en && !w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign w_oh16 = 16'(o_grant);
    assign w_idx4 = onehot_to_index(w_oh16);
    assign o_idx  = ID_WIDTH'(w_idx4);
    assign o_any  = |o_grant;

endmodule

// File: rtl/filter_rr_scheduler.sv
// Round-robin read scheduler for the filter buffer bank. Issues one one-hot
// pop per cycle when the force pipeline is ready, and delays {valid, id}
// by READ_LATENCY so it lines up with the buffer read data.
// Optional statistics ports are enabled by defining FILTER_SCHED_STATS_EN.
module filter_rr_scheduler
    import md_filter_pkg::*;
#(
    parameter int unsigned NUM_FILTER   = 4,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    filter_rr_scheduler_if.master       bus
`ifdef FILTER_SCHED_STATS_EN
    ,
    output logic [NUM_FILTER*STATS_W-1:0] grant_total,
    output logic [STATS_W-1:0]            stall_cycles
`endif
);
    sched_state_t          w_state;
    sched_state_t          r_state;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [NUM_FILTER-1:0] w_grant;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_any;
    logic                  r_dv  [READ_LATENCY];
    logic [ID_WIDTH-1:0]   r_did [READ_LATENCY];
    logic [2:0]            r_cnt;

    // Classify the current cycle from the request and ready inputs
    always_comb begin
        w_state = IDLE;
        if (|bus.filter_available) w_state = bus.pipe_ready ? ACTIVE : STALL;
    end

    // Grants are suppressed while reset is asserted
    rr_pick #(
        .NUM_FILTER (NUM_FILTER),
        .ID_WIDTH   (ID_WIDTH)
    ) u_pick (
        .i_req   (bus.filter_available),
        .i_ptr   (r_ptr),
        .i_en    ((w_state == ACTIVE) && !rst),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // State register and priority pointer advance past the granted filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state;
            if (w_any) begin
                r_ptr <= (w_idx == ID_WIDTH'(NUM_FILTER - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // Delay line carrying {valid, id} to align with buffer read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_dv[i]  <= 1'b0;
                r_did[i] <= '0;
            end
        end else begin
            r_dv[0]  <= w_any;
            r_did[0] <= w_idx;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_dv[i]  <= r_dv[i-1];
                r_did[i] <= r_did[i-1];
            end
        end
    end

    // In-flight count: +1 on grant, -1 when data emerges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + {2'b00, w_any} - {2'b00, r_dv[READ_LATENCY-1]};
    end

    assign bus.arbitration_result = w_grant;
    assign bus.sel_valid          = r_dv[READ_LATENCY-1];
    assign bus.sel_id             = r_did[READ_LATENCY-1];
    assign bus.inflight_cnt       = r_cnt;
    assign bus.arb_busy           = (r_state != IDLE);

`ifdef FILTER_SCHED_STATS_EN
    stat_cnt_t r_gtot [NUM_FILTER];
    stat_cnt_t r_stall;

    // Saturating per-filter grant counters and stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FILTER; i++) r_gtot[i] <= '0;
            r_stall <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FILTER; i++) begin
                if (w_grant[i] && (r_gtot[i] != '1)) r_gtot[i] <= r_gtot[i] + 1'b1;
            end
            if ((w_state == STALL) && (r_stall != '1)) r_stall <= r_stall + 1'b1;
        end
    end

    // Flatten the per-filter counters onto the output bus
    always_comb begin
        grant_total = '0;
        for (int unsigned i = 0; i < NUM_FILTER; i++) begin
            grant_total[i*STATS_W +: STATS_W] = r_gtot[i];
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_filter_rr_scheduler.sv
// Directed, table-driven bench for filter_rr_scheduler (READ_LATENCY 1 and 3).
module tb_filter_rr_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    filter_rr_scheduler_if #(.NUM_FILTER(4), .ID_WIDTH(2)) ifc1 ();
    filter_rr_scheduler_if #(.NUM_FILTER(4), .ID_WIDTH(2)) ifc3 ();

`ifdef FILTER_SCHED_STATS_EN
    logic [63:0] gt1, gt3;
    logic [15:0] sc1, sc3;
`endif

    filter_rr_scheduler #(.NUM_FILTER(4), .ID_WIDTH(2), .READ_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
`ifdef FILTER_SCHED_STATS_EN
        , .grant_total (gt1), .stall_cycles (sc1)
`endif
    );

    filter_rr_scheduler #(.NUM_FILTER(4), .ID_WIDTH(2), .READ_LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (ifc3)
`ifdef FILTER_SCHED_STATS_EN
        , .grant_total (gt3), .stall_cycles (sc3)
`endif
    );

    typedef struct {
        logic [3:0] avail;
        logic       rdy;
        logic [3:0] g;
        logic       sv;
        logic [1:0] id;
        logic [2:0] cnt;
        logic       busy;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int gcnt [4];

        // avail, ready, grant, sel_valid, sel_id, inflight, busy
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 3'd1, 1'b1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 3'd1, 1'b1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 3'd1, 1'b1};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd0, 3'd1, 1'b1};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1, 3'd1, 1'b1};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3, 3'd1, 1'b1};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 3'd1, 1'b1};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[12] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3, 3'd1, 1'b1};
        vecs[14] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[16] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[17] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 3'd1, 1'b1};
        vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0};

        rst  = 1'b1;
        rst3 = 1'b1;
        ifc1.filter_available = 4'b1111;
        ifc1.pipe_ready       = 1'b1;
        ifc3.filter_available = 4'b0000;
        ifc3.pipe_ready       = 1'b1;

        // Reset held with all filters requesting
        repeat (2) @(negedge clk);
        #1;
        check("rst grant",    32'(ifc1.arbitration_result), 32'd0);
        check("rst sel_valid", 32'(ifc1.sel_valid),        32'd0);
        check("rst sel_id",   32'(ifc1.sel_id),             32'd0);
        check("rst inflight", 32'(ifc1.inflight_cnt),       32'd0);
        check("rst busy",     32'(ifc1.arb_busy),           32'd0);

        // Table-driven sequence: rotation, sparse, stall, single requester
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            ifc1.filter_available = vecs[i].avail;
            ifc1.pipe_ready       = vecs[i].rdy;
            #1;
            check($sformatf("v%0d grant", i),    32'(ifc1.arbitration_result), 32'(vecs[i].g));
            check($sformatf("v%0d sel_valid", i), 32'(ifc1.sel_valid),        32'(vecs[i].sv));
            if (vecs[i].sv)
                check($sformatf("v%0d sel_id", i), 32'(ifc1.sel_id),          32'(vecs[i].id));
            check($sformatf("v%0d inflight", i), 32'(ifc1.inflight_cnt),      32'(vecs[i].cnt));
            check($sformatf("v%0d busy", i),     32'(ifc1.arb_busy),          32'(vecs[i].busy));
        end

`ifdef FILTER_SCHED_STATS_EN
        check("l1 grant_total f0", 32'(gt1[15:0]),  32'd2);
        check("l1 grant_total f1", 32'(gt1[31:16]), 32'd3);
        check("l1 grant_total f2", 32'(gt1[47:32]), 32'd7);
        check("l1 grant_total f3", 32'(gt1[63:48]), 32'd3);
        check("l1 stall_cycles",   32'(sc1),        32'd3);
`endif

        // READ_LATENCY=3: fill the delay line, then async reset mid-burst
        @(negedge clk);
        rst3 = 1'b0;
        ifc3.filter_available = 4'b1111;
        #1;
        check("l3 c0 grant", 32'(ifc3.arbitration_result), 32'b0001);
        @(negedge clk); #1;
        check("l3 c1 inflight", 32'(ifc3.inflight_cnt), 32'd1);
        check("l3 c1 sel_valid", 32'(ifc3.sel_valid), 32'd0);
        @(negedge clk); #1;
        check("l3 c2 inflight", 32'(ifc3.inflight_cnt), 32'd2);
        check("l3 c2 sel_valid", 32'(ifc3.sel_valid), 32'd0);
        @(negedge clk); #1;
        check("l3 c3 sel_valid", 32'(ifc3.sel_valid),          32'd1);
        check("l3 c3 sel_id",    32'(ifc3.sel_id),             32'd0);
        check("l3 c3 inflight",  32'(ifc3.inflight_cnt),       32'd3);
        check("l3 c3 grant",     32'(ifc3.arbitration_result), 32'b1000);
        #2;
        rst3 = 1'b1;
        #1;
        check("l3 async sel_valid", 32'(ifc3.sel_valid),          32'd0);
        check("l3 async inflight",  32'(ifc3.inflight_cnt),       32'd0);
        check("l3 async grant",     32'(ifc3.arbitration_result), 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        check("l3 post-rst grant", 32'(ifc3.arbitration_result), 32'b0001);

        // Fairness: 40 cycles with every filter requesting
        for (int b = 0; b < 4; b++) gcnt[b] = 0;
        for (int c = 0; c < 40; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (ifc3.arbitration_result[b]) gcnt[b]++;
            end
            @(negedge clk);
            #1;
        end
        for (int b = 0; b < 4; b++) begin
            check($sformatf("fair f%0d", b), 32'(gcnt[b]), 32'd10);
        end
`ifdef FILTER_SCHED_STATS_EN
        for (int b = 0; b < 4; b++) begin
            check($sformatf("l3 grant_total f%0d", b), 32'(gt3[b*16 +: 16]), 32'd10);
        end
        check("l3 stall_cycles", 32'(sc3), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
